// File: rtl/ber_accum.sv
// Bit-error-rate accumulator: compares tx/rx word pairs over a measurement window.
// Define BER_ACCUM_SATURATE_EN for saturating accumulators; the default build wraps.
module ber_accum #(
  parameter int WIDTH = 13,
  parameter int CNT_W = 32,
  parameter int WIN_W = 32,
  localparam int EW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [WIN_W-1:0] window_len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] tx_word,
  input  logic [WIDTH-1:0] rx_word,
  output logic             in_ready,
  output logic [WIDTH-1:0] error_vec,
  output logic [EW-1:0]    word_err,
  output logic [CNT_W-1:0] total_err,
  output logic [CNT_W-1:0] total_bits,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             drain_cnt;
  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] word_cnt;
  logic [WIN_W-1:0] cnt_inc;
  logic             accept;
  logic             go;
  logic             v1;
  logic [EW-1:0]    pc;
  logic [CNT_W:0]   err_sum;
  logic [CNT_W:0]   bit_sum;

  function automatic logic [EW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [EW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + EW'(v[i]);
    return n;
  endfunction

  assign accept  = in_valid && in_ready;
  assign cnt_inc = (word_cnt == '1) ? word_cnt : word_cnt + WIN_W'(1);
  assign go      = (state_nxt == RUN) && (state != RUN);
  assign pc      = popcount(error_vec);
  assign err_sum = {1'b0, total_err} + (CNT_W + 1)'(pc);
  assign bit_sum = {1'b0, total_bits} + (CNT_W + 1)'(WIDTH);

  // Stop beats start, clear beats everything; a window of zero never ends by count.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start && !stop) state_nxt = RUN;
      RUN:   if (stop || (accept && win != '0 && cnt_inc == win)) state_nxt = DRAIN;
      DRAIN: if (drain_cnt) state_nxt = DONE;
      DONE:  if (start && !stop) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= 1'b0;
      win       <= '0;
      word_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == RUN);
      busy      <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done      <= (state_nxt == DONE);
      drain_cnt <= (state_nxt == DRAIN) && (state == DRAIN);
      if (clear) begin
        win      <= '0;
        word_cnt <= '0;
      end else if (go) begin
        win      <= window_len;
        word_cnt <= '0;
      end else if (accept) begin
        word_cnt <= cnt_inc;
      end
    end
  end

  // Two-stage datapath: XOR capture, then popcount and accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      error_vec  <= '0;
      word_err   <= '0;
      total_err  <= '0;
      total_bits <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      v1         <= 1'b0;
      error_vec  <= '0;
      word_err   <= '0;
      total_err  <= '0;
      total_bits <= '0;
      overflow   <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) error_vec <= tx_word ^ rx_word;
      if (go) begin
        total_err  <= '0;
        total_bits <= '0;
        overflow   <= 1'b0;
      end else if (v1) begin
        word_err <= pc;
`ifdef BER_ACCUM_SATURATE_EN
        total_err  <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        total_bits <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
`else
        total_err  <= err_sum[CNT_W-1:0];
        total_bits <= bit_sum[CNT_W-1:0];
`endif
        if (err_sum[CNT_W] || bit_sum[CNT_W]) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ber_accum.sv
// Self-checking bench for ber_accum: directed table, corner sequences, randomized measurements.
module tb_ber_accum;
  localparam int WIDTH = 13;
  localparam int CNT_W = 8;
  localparam int WIN_W = 8;
  localparam int EW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0, stop = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [WIN_W-1:0] window_len = '0;
  logic [WIDTH-1:0] tx_word = '0, rx_word = '0;
  logic             in_ready, busy, done, overflow;
  logic [WIDTH-1:0] error_vec;
  logic [EW-1:0]    word_err;
  logic [CNT_W-1:0] total_err, total_bits;

  int nVec = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  ber_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .window_len(window_len), .in_valid(in_valid), .tx_word(tx_word), .rx_word(rx_word),
    .in_ready(in_ready), .error_vec(error_vec), .word_err(word_err),
    .total_err(total_err), .total_bits(total_bits), .busy(busy), .done(done),
    .overflow(overflow)
  );

  typedef struct {
    logic             st, sp, cl, v;
    logic [WIDTH-1:0] tx, rx;
    logic [WIN_W-1:0] win;
    logic             rdy, bsy, dn, ov;
    logic [WIDTH-1:0] ev;
    logic [EW-1:0]    we;
    logic [CNT_W-1:0] te, tb;
  } vec_t;

  vec_t tbl[20];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic c, input logic v,
                               input logic [WIDTH-1:0] tx, input logic [WIDTH-1:0] rx,
                               input logic [WIN_W-1:0] w);
    start = s; stop = p; clear = c; in_valid = v;
    tx_word = tx; rx_word = rx; window_len = w;
    @(posedge clk);
    #1;
  endtask

  // Expected accumulator value for a true (unbounded) sum.
  function automatic logic [CNT_W-1:0] accExp(input int sum);
    int lim;
    lim = (1 << CNT_W) - 1;
`ifdef BER_ACCUM_SATURATE_EN
    return CNT_W'((sum > lim) ? lim : sum);
`else
    return CNT_W'(sum % (lim + 1));
`endif
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " in_ready"}, in_ready, 0);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " overflow"}, overflow, 0);
    checkOutput({tag, " error_vec"}, error_vec, 0);
    checkOutput({tag, " word_err"}, word_err, 0);
    checkOutput({tag, " total_err"}, total_err, 0);
    checkOutput({tag, " total_bits"}, total_bits, 0);
  endtask

  // Drains after the ending edge and checks final totals against the true sums.
  task automatic finishMeasurement(input string tag, input int sumErr, input int nAcc);
    int bits;
    bits = nAcc * WIDTH;
    checkOutput({tag, " drain in_ready"}, in_ready, 0);
    checkOutput({tag, " drain busy"}, busy, 1);
    checkOutput({tag, " drain done"}, done, 0);
    applyStimulus(0, 0, 0, 0, '0, '0, '0);
    checkOutput({tag, " drain2 busy"}, busy, 1);
    checkOutput({tag, " drain2 done"}, done, 0);
    applyStimulus(0, 0, 0, 0, '0, '0, '0);
    checkOutput({tag, " done"}, done, 1);
    checkOutput({tag, " done busy"}, busy, 0);
    checkOutput({tag, " total_err"}, total_err, accExp(sumErr));
    checkOutput({tag, " total_bits"}, total_bits, accExp(bits));
    checkOutput({tag, " overflow"}, overflow, (sumErr >= (1 << CNT_W)) || (bits >= (1 << CNT_W)));
  endtask

  initial begin : main
    int w, stopAt, sumErr, nAcc, cyc;
    logic running, v, p;
    logic [WIDTH-1:0] tx, rx;

    tbl[0]  = '{1,0,0,0, 13'h0000, 13'h0000, 4, 1,1,0,0, 13'h0000, 0, 0,  0};
    tbl[1]  = '{0,0,0,1, 13'h0A5A, 13'h0A5A, 4, 1,1,0,0, 13'h0000, 0, 0,  0};
    tbl[2]  = '{0,0,0,1, 13'h1234, 13'h0DCB, 4, 1,1,0,0, 13'h1FFF, 0, 0, 13};
    tbl[3]  = '{0,0,0,1, 13'h0F0F, 13'h0F0F, 4, 1,1,0,0, 13'h0000,13,13, 26};
    tbl[4]  = '{0,0,0,1, 13'h1001, 13'h1001, 4, 0,1,0,0, 13'h0000, 0,13, 39};
    tbl[5]  = '{0,0,0,1, 13'h0001, 13'h0000, 4, 0,1,0,0, 13'h0000, 0,13, 52};
    tbl[6]  = '{0,0,0,0, 13'h0000, 13'h0000, 4, 0,0,1,0, 13'h0000, 0,13, 52};
    tbl[7]  = '{0,0,0,0, 13'h0000, 13'h0000, 4, 0,0,1,0, 13'h0000, 0,13, 52};
    tbl[8]  = '{1,0,0,0, 13'h0000, 13'h0000, 2, 1,1,0,0, 13'h0000, 0, 0,  0};
    tbl[9]  = '{0,0,0,1, 13'h0100, 13'h0101, 2, 1,1,0,0, 13'h0001, 0, 0,  0};
    tbl[10] = '{0,0,0,0, 13'h1FFF, 13'h0000, 2, 1,1,0,0, 13'h0001, 1, 1, 13};
    tbl[11] = '{0,0,0,1, 13'h0200, 13'h0000, 2, 0,1,0,0, 13'h0200, 1, 1, 13};
    tbl[12] = '{0,0,0,0, 13'h0000, 13'h0000, 2, 0,1,0,0, 13'h0200, 1, 2, 26};
    tbl[13] = '{0,0,0,0, 13'h0000, 13'h0000, 2, 0,0,1,0, 13'h0200, 1, 2, 26};
    tbl[14] = '{0,0,1,0, 13'h0000, 13'h0000, 2, 0,0,0,0, 13'h0000, 0, 0,  0};
    tbl[15] = '{1,1,0,0, 13'h0000, 13'h0000, 2, 0,0,0,0, 13'h0000, 0, 0,  0};
    tbl[16] = '{1,0,0,0, 13'h0000, 13'h0000, 0, 1,1,0,0, 13'h0000, 0, 0,  0};
    tbl[17] = '{1,0,0,1, 13'h0003, 13'h0000, 0, 1,1,0,0, 13'h0003, 0, 0,  0};
    tbl[18] = '{1,1,1,0, 13'h0000, 13'h0000, 0, 0,0,0,0, 13'h0000, 0, 0,  0};
    tbl[19] = '{0,0,0,0, 13'h0000, 13'h0000, 0, 0,0,0,0, 13'h0000, 0, 0,  0};

    #2;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Window, stall, priority and clear-flush behaviour.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].v, tbl[i].tx, tbl[i].rx, tbl[i].win);
      checkOutput($sformatf("tbl[%0d] in_ready", i), in_ready, tbl[i].rdy);
      checkOutput($sformatf("tbl[%0d] busy", i), busy, tbl[i].bsy);
      checkOutput($sformatf("tbl[%0d] done", i), done, tbl[i].dn);
      checkOutput($sformatf("tbl[%0d] overflow", i), overflow, tbl[i].ov);
      checkOutput($sformatf("tbl[%0d] error_vec", i), error_vec, tbl[i].ev);
      checkOutput($sformatf("tbl[%0d] word_err", i), word_err, tbl[i].we);
      checkOutput($sformatf("tbl[%0d] total_err", i), total_err, tbl[i].te);
      checkOutput($sformatf("tbl[%0d] total_bits", i), total_bits, tbl[i].tb);
    end

    // Early stop with an unbounded window.
    applyStimulus(1, 0, 0, 0, '0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      tx = WIDTH'($urandom);
      applyStimulus(0, 0, 0, 1, tx, tx ^ 13'h0010, 0);
    end
    applyStimulus(0, 1, 0, 0, '0, '0, 0);
    finishMeasurement("early_stop", 5, 5);

    // Every bit in error for 20 words pushes the 8-bit accumulators past their limit.
    applyStimulus(1, 0, 0, 0, '0, '0, 0);
    for (int i = 0; i < 20; i++) begin
      tx = WIDTH'($urandom);
      applyStimulus(0, 0, 0, 1, tx, ~tx, 0);
    end
    applyStimulus(0, 1, 0, 0, '0, '0, 0);
    finishMeasurement("overflow", 260, 20);

    // Asynchronous reset between clock edges in the middle of a run.
    applyStimulus(1, 0, 0, 0, '0, '0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 13'h0000, 13'h0007, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, '0, '0, 0);
    checkOutput("post_rst in_ready", in_ready, 1);
    applyStimulus(0, 0, 0, 1, 13'h0ABC, 13'h0ABF, 0);
    applyStimulus(0, 1, 0, 0, '0, '0, 0);
    finishMeasurement("post_rst", 2, 1);

    // Randomized measurements against the running-sum model.
    for (int m = 0; m < 30; m++) begin
      w = $urandom_range(0, 6);
      stopAt = $urandom_range(2, 24);
      sumErr = 0;
      nAcc = 0;
      cyc = 0;
      running = 1'b1;
      applyStimulus(1, 0, 0, 0, '0, '0, WIN_W'(w));
      checkOutput("rnd start total_err", total_err, 0);
      checkOutput("rnd start total_bits", total_bits, 0);
      checkOutput("rnd start overflow", overflow, 0);
      while (running) begin
        v = ($urandom_range(0, 9) < 7);
        tx = WIDTH'($urandom);
        rx = tx ^ WIDTH'($urandom & $urandom);
        p = (w == 0 && cyc >= stopAt) || ($urandom_range(0, 29) == 0) || (cyc >= 100);
        checkOutput("rnd in_ready", in_ready, 1);
        applyStimulus(0, p, 0, v, tx, rx, WIN_W'(w));
        if (v) begin
          nAcc++;
          sumErr += $countones(tx ^ rx);
          checkOutput("rnd error_vec", error_vec, tx ^ rx);
        end
        cyc++;
        if (p || (w != 0 && nAcc == w)) running = 1'b0;
      end
      finishMeasurement($sformatf("rnd[%0d]", m), sumErr, nAcc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
